pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the pipelined MIPS core; one instance per boundary (D/E, E/M, M/W).
- Carries the instruction word, PC, destination register and hazard timers, plus a generic payload bus for RD1/RD2/ALU/Data and similar values.
- Adds a valid bit, stall hold, flush-to-bubble, a sentinel-preserving timer decrement and a stall-duration counter.

Parameters:
- PAYLOAD_W, 96: width of the concatenated payload bus.
- TW, 2: width of each Tuse/Tnew timer; TMAX = 2^TW-1.
- PC_RESET, 32'h0000_3000: PC value loaded on reset or bubble.
- SCNT_W, 8: width of the stall-duration counter.

Ports:
- clk  input  1  clock
- reset  input  1  sync active-high reset
- stall  input  1  hold current contents
- flush  input  1  replace contents with a bubble
- valid_i  input  1  upstream holds a real instruction
- ins_i  input  32  instruction word
- pc_i  input  32  instruction PC
- a3_i  input  5  destination GPR (0 = none)
- tuse_rs_i  input  TW  Tuse of rs
- tuse_rt_i  input  TW  Tuse of rt
- tnew_i  input  TW  Tnew of result
- payload_i  input  PAYLOAD_W  data fields
- valid_o  output  1  registered valid
- ins_o  output  32
- pc_o  output  32
- a3_o  output  5
- tuse_rs_o  output  TW
- tuse_rt_o  output  TW
- tnew_o  output  TW
- payload_o  output  PAYLOAD_W
- wr_pending_o  output  1  combinational: valid_o && a3_o!=0
- stall_cnt_o  output  SCNT_W  consecutive stalled cycles

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All outputs change only on posedge clk.
- Bubble value:
  - valid 0, ins 0, a3 0, payload 0.
  - tuse_rs and tuse_rt = TMAX; tnew 0.
  - pc = PC_RESET.
- Priority per clock edge: reset > flush > stall > load.
  - reset: bubble; stall_cnt 0.
  - flush: bubble; stall_cnt 0. Flush overrides a simultaneous stall.
  - stall: every field holds unchanged, timers included; stall_cnt = min(stall_cnt+1, 2^SCNT_W-1), saturating.
  - load with valid_i=1: ins, pc, a3 and payload copied. Timers transformed as below. valid_o=1, stall_cnt 0.
  - load with valid_i=0: bubble value loaded, whatever the data inputs are; stall_cnt 0.
- Timer transform on load, applied independently to each field:
  - Tuse: input == TMAX is the "unused" sentinel and passes through unchanged. Input 0 stays 0. Otherwise input-1.
  - Tnew: 0 stays 0; otherwise tnew_i-1. TMAX is not a sentinel for Tnew.
  - No wrap-around is permitted on any timer.
- Latency: one cycle from inputs to outputs; no combinational path from inputs to outputs.
- wr_pending_o is derived only from registered state.
- Reset during a stall: reset wins; the stall counter clears.
- Initial block values equal the bubble value, so simulation starts clean without reset.

Optional Feature:
- Macro: PIPE_KEEP_PC_ON_FLUSH_EN.
- Defined: on flush only, pc_o is loaded with pc_i instead of PC_RESET, and a new output bubble_pc_vld_o (1 bit) is set to 1. This supports precise-exception PC reporting. reset still loads PC_RESET and clears bubble_pc_vld_o. Any load or stall-free cycle other than flush clears bubble_pc_vld_o.
- Undefined: flush loads PC_RESET; the port bubble_pc_vld_o does not exist.

Test Plan:
- Reset: assert reset 1 cycle -> valid_o=0, pc_o=0x3000, tuse_rs_o=tuse_rt_o=3, tnew_o=0, stall_cnt_o=0.
- Load: valid_i=1, ins 0x8C220004, pc 0x3004, a3 2, tuse_rs 1, tuse_rt 3, tnew 2 -> next cycle ins/pc/a3 copied, tuse_rs_o=0, tuse_rt_o=3 (sentinel), tnew_o=1, wr_pending_o=1.
- Saturation: tuse_rs=0, tnew=0 loaded -> outputs 0, no wrap to 3.
- Stall: load as above, then stall=1 for 4 cycles with changing inputs -> outputs frozen, stall_cnt_o 1,2,3,4; release -> new data loads, stall_cnt_o=0. With SCNT_W=2, stall 6 cycles -> stall_cnt_o holds at 3.
- Flush vs stall: stall=1 and flush=1 together -> bubble, valid_o=0, pc_o=0x3000. With PIPE_KEEP_PC_ON_FLUSH_EN, pc_o=pc_i and bubble_pc_vld_o=1.
- Invalid load: valid_i=0 with nonzero ins/a3 -> valid_o=0, a3_o=0, wr_pending_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Inter-stage pipeline register for the pipelined MIPS core
//            (one instance per D/E, E/M, M/W boundary). Carries instruction,
//            PC, destination register, hazard timers and a generic payload
//            bus, with a valid bit, stall hold, flush-to-bubble,
//            sentinel-preserving timer decrement and a saturating
//            stall-duration counter.
// Ports    : clk, reset (sync, active-high), stall, flush
//            valid_i, ins_i, pc_i, a3_i, tuse_rs_i, tuse_rt_i, tnew_i,
//            payload_i                      -> upstream stage fields
//            valid_o, ins_o, pc_o, a3_o, tuse_rs_o, tuse_rt_o, tnew_o,
//            payload_o                      -> registered stage fields
//            wr_pending_o                   -> valid_o && a3_o != 0
//            stall_cnt_o                    -> consecutive stalled cycles
//            bubble_pc_vld_o                -> only with the macro below
// Options  : `define PIPE_KEEP_PC_ON_FLUSH_EN to keep pc_i in a flushed
//            bubble and report it through bubble_pc_vld_o.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int          PAYLOAD_W = 96,
  parameter int          TW        = 2,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int          SCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_i,
  input  logic [31:0]          ins_i,
  input  logic [31:0]          pc_i,
  input  logic [4:0]           a3_i,
  input  logic [TW-1:0]        tuse_rs_i,
  input  logic [TW-1:0]        tuse_rt_i,
  input  logic [TW-1:0]        tnew_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [31:0]          ins_o,
  output logic [31:0]          pc_o,
  output logic [4:0]           a3_o,
  output logic [TW-1:0]        tuse_rs_o,
  output logic [TW-1:0]        tuse_rt_o,
  output logic [TW-1:0]        tnew_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic                 wr_pending_o,
  output logic [SCNT_W-1:0]    stall_cnt_o
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
  ,
  output logic                 bubble_pc_vld_o
`endif
);

  localparam logic [TW-1:0]     c_TMAX      = {TW{1'b1}};
  localparam logic [TW-1:0]     c_TW_ONE    = TW'(1);
  localparam logic [SCNT_W-1:0] c_SCNT_MAX  = {SCNT_W{1'b1}};
  localparam logic [SCNT_W-1:0] c_SCNT_ONE  = SCNT_W'(1);

  // Tuse: all-ones means "operand unused" and must survive every stage;
  // zero is already the tightest requirement and must not wrap.
  function automatic logic [TW-1:0] f_tuse_next(input logic [TW-1:0] t);
    if ((t == c_TMAX) || (t == '0)) return t;
    return t - c_TW_ONE;
  endfunction

  // Tnew: counts down to zero and sticks there; all-ones is an ordinary value.
  function automatic logic [TW-1:0] f_tnew_next(input logic [TW-1:0] t);
    if (t == '0) return t;
    return t - c_TW_ONE;
  endfunction

  // Registered state; declaration values equal the bubble so that a
  // simulation without an initial reset still starts from a clean bubble.
  logic                 r_valid   = 1'b0;
  logic [31:0]          r_ins     = '0;
  logic [31:0]          r_pc      = PC_RESET;
  logic [4:0]           r_a3      = '0;
  logic [TW-1:0]        r_tuse_rs = {TW{1'b1}};
  logic [TW-1:0]        r_tuse_rt = {TW{1'b1}};
  logic [TW-1:0]        r_tnew    = '0;
  logic [PAYLOAD_W-1:0] r_payload = '0;
  logic [SCNT_W-1:0]    r_scnt    = '0;
  logic                 r_bpv     = 1'b0;

  logic                 w_valid;
  logic [31:0]          w_ins;
  logic [31:0]          w_pc;
  logic [4:0]           w_a3;
  logic [TW-1:0]        w_tuse_rs;
  logic [TW-1:0]        w_tuse_rt;
  logic [TW-1:0]        w_tnew;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [SCNT_W-1:0]    w_scnt;
  logic                 w_bpv;

  logic w_hold;       // stall wins this edge: every field keeps its value
  logic w_flush_eff;  // flush wins this edge
  logic w_bubble;     // bubble loaded for any reason

  assign w_flush_eff = !reset && flush;
  assign w_hold      = !reset && !flush && stall;
  assign w_bubble    = reset || flush || (!stall && !valid_i);

  always_comb begin
    w_valid   = r_valid;
    w_ins     = r_ins;
    w_pc      = r_pc;
    w_a3      = r_a3;
    w_tuse_rs = r_tuse_rs;
    w_tuse_rt = r_tuse_rt;
    w_tnew    = r_tnew;
    w_payload = r_payload;

    if (w_bubble) begin
      w_valid   = 1'b0;
      w_ins     = '0;
      w_a3      = '0;
      w_tuse_rs = c_TMAX;
      w_tuse_rt = c_TMAX;
      w_tnew    = '0;
      w_payload = '0;
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
      // Keep the faulting/flushed PC for precise exception reporting.
      w_pc      = w_flush_eff ? pc_i : PC_RESET;
`else
      w_pc      = PC_RESET;
`endif
    end else if (!w_hold) begin
      w_valid   = 1'b1;
      w_ins     = ins_i;
      w_pc      = pc_i;
      w_a3      = a3_i;
      w_tuse_rs = f_tuse_next(tuse_rs_i);
      w_tuse_rt = f_tuse_next(tuse_rt_i);
      w_tnew    = f_tnew_next(tnew_i);
      w_payload = payload_i;
    end
  end

  // Stall counter only advances on cycles that actually hold; every other
  // outcome (reset, flush, load, bubble) restarts it.
  always_comb begin
    w_scnt = '0;
    if (w_hold) begin
      w_scnt = (r_scnt == c_SCNT_MAX) ? r_scnt : (r_scnt + c_SCNT_ONE);
    end
  end

  // Bubble-PC flag: set by flush, held by stall, cleared by everything else.
  assign w_bpv = w_hold ? r_bpv : w_flush_eff;

  always_ff @(posedge clk) begin
    r_valid   <= w_valid;
    r_ins     <= w_ins;
    r_pc      <= w_pc;
    r_a3      <= w_a3;
    r_tuse_rs <= w_tuse_rs;
    r_tuse_rt <= w_tuse_rt;
    r_tnew    <= w_tnew;
    r_payload <= w_payload;
    r_scnt    <= w_scnt;
    r_bpv     <= w_bpv;
  end

  assign valid_o      = r_valid;
  assign ins_o        = r_ins;
  assign pc_o         = r_pc;
  assign a3_o         = r_a3;
  assign tuse_rs_o    = r_tuse_rs;
  assign tuse_rt_o    = r_tuse_rt;
  assign tnew_o       = r_tnew;
  assign payload_o    = r_payload;
  assign stall_cnt_o  = r_scnt;
  assign wr_pending_o = r_valid && (r_a3 != 5'd0);

`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
  assign bubble_pc_vld_o = r_bpv;
`else
  logic w_unused_bpv;
  assign w_unused_bpv = r_bpv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Scenario tasks with
//            directed values, plus a randomized run against a behavioural
//            model. A second instance with SCNT_W=2 exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int          PW   = 96;
  localparam int          TW   = 2;
  localparam logic [31:0] PCR  = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0, stall = 1'b0, flush = 1'b0, valid_i = 1'b0;
  logic [31:0]   ins_i = '0, pc_i = '0;
  logic [4:0]    a3_i = '0;
  logic [TW-1:0] tuse_rs_i = '0, tuse_rt_i = '0, tnew_i = '0;
  logic [PW-1:0] payload_i = '0;

  logic          valid_o, wr_pending_o;
  logic [31:0]   ins_o, pc_o;
  logic [4:0]    a3_o;
  logic [TW-1:0] tuse_rs_o, tuse_rt_o, tnew_o;
  logic [PW-1:0] payload_o;
  logic [7:0]    stall_cnt_o;

  // Small-counter instance: only its stall counter is checked.
  logic          s_valid_o, s_wr_pending_o;
  logic [31:0]   s_ins_o, s_pc_o;
  logic [4:0]    s_a3_o;
  logic [TW-1:0] s_tuse_rs_o, s_tuse_rt_o, s_tnew_o;
  logic [PW-1:0] s_payload_o;
  logic [1:0]    s_stall_cnt_o;
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
  logic          bubble_pc_vld_o, s_bubble_pc_vld_o;
`endif

  pipe_stage_reg #(.PAYLOAD_W(PW), .TW(TW), .PC_RESET(PCR), .SCNT_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ins_i(ins_i), .pc_i(pc_i), .a3_i(a3_i), .tuse_rs_i(tuse_rs_i),
    .tuse_rt_i(tuse_rt_i), .tnew_i(tnew_i), .payload_i(payload_i),
    .valid_o(valid_o), .ins_o(ins_o), .pc_o(pc_o), .a3_o(a3_o),
    .tuse_rs_o(tuse_rs_o), .tuse_rt_o(tuse_rt_o), .tnew_o(tnew_o),
    .payload_o(payload_o), .wr_pending_o(wr_pending_o),
    .stall_cnt_o(stall_cnt_o)
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
    , .bubble_pc_vld_o(bubble_pc_vld_o)
`endif
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .TW(TW), .PC_RESET(PCR), .SCNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ins_i(ins_i), .pc_i(pc_i), .a3_i(a3_i), .tuse_rs_i(tuse_rs_i),
    .tuse_rt_i(tuse_rt_i), .tnew_i(tnew_i), .payload_i(payload_i),
    .valid_o(s_valid_o), .ins_o(s_ins_o), .pc_o(s_pc_o), .a3_o(s_a3_o),
    .tuse_rs_o(s_tuse_rs_o), .tuse_rt_o(s_tuse_rt_o), .tnew_o(s_tnew_o),
    .payload_o(s_payload_o), .wr_pending_o(s_wr_pending_o),
    .stall_cnt_o(s_stall_cnt_o)
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
    , .bubble_pc_vld_o(s_bubble_pc_vld_o)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [4:0] a3, input logic [TW-1:0] trs,
                       input logic [TW-1:0] trt, input logic [TW-1:0] tn,
                       input logic [PW-1:0] pl);
    valid_i = v; ins_i = ins; pc_i = pc; a3_i = a3;
    tuse_rs_i = trs; tuse_rt_i = trt; tnew_i = tn; payload_i = pl;
  endtask

  // ---------------------------------------------------------------- reset
  task automatic test_reset();
    // Counter starts from the declared clean state; two stalls count to 2.
    stall = 1'b1; tick(); tick();
    checks++; if (stall_cnt_o !== 8'd2) $display("FAIL init_stall_cnt got=%0d exp=2", stall_cnt_o); else passed++;
    // Reset during a stall wins and clears the counter.
    reset = 1'b1; tick();
    reset = 1'b0; stall = 1'b0;
    checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid_o); else passed++;
    checks++; if (pc_o !== 32'h3000) $display("FAIL reset_pc got=%h exp=00003000", pc_o); else passed++;
    checks++; if (tuse_rs_o !== 2'd3 || tuse_rt_o !== 2'd3) $display("FAIL reset_tuse got=%0d/%0d exp=3/3", tuse_rs_o, tuse_rt_o); else passed++;
    checks++; if (tnew_o !== 2'd0) $display("FAIL reset_tnew got=%0d exp=0", tnew_o); else passed++;
    checks++; if (stall_cnt_o !== 8'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt_o); else passed++;
    checks++; if (ins_o !== 32'd0 || a3_o !== 5'd0 || payload_o !== '0) $display("FAIL reset_data got=%h/%0d exp=0/0", ins_o, a3_o); else passed++;
  endtask

  // ----------------------------------------------------------------- load
  task automatic test_load();
    logic [PW-1:0] pl;
    pl = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    drive(1'b1, 32'h8C22_0004, 32'h3004, 5'd2, 2'd1, 2'd3, 2'd2, pl);
    tick();
    checks++; if (ins_o !== 32'h8C22_0004) $display("FAIL load_ins got=%h exp=8c220004", ins_o); else passed++;
    checks++; if (pc_o !== 32'h3004 || a3_o !== 5'd2) $display("FAIL load_pc_a3 got=%h/%0d exp=00003004/2", pc_o, a3_o); else passed++;
    checks++; if (tuse_rs_o !== 2'd0) $display("FAIL load_tuse_rs got=%0d exp=0", tuse_rs_o); else passed++;
    checks++; if (tuse_rt_o !== 2'd3) $display("FAIL load_tuse_rt_sentinel got=%0d exp=3", tuse_rt_o); else passed++;
    checks++; if (tnew_o !== 2'd1) $display("FAIL load_tnew got=%0d exp=1", tnew_o); else passed++;
    checks++; if (valid_o !== 1'b1 || wr_pending_o !== 1'b1) $display("FAIL load_valid_wrp got=%0b/%0b exp=1/1", valid_o, wr_pending_o); else passed++;
    checks++; if (payload_o !== pl) $display("FAIL load_payload got=%h exp=%h", payload_o, pl); else passed++;
  endtask

  // ----------------------------------------------------------- saturation
  task automatic test_saturation();
    drive(1'b1, 32'h1111_0000, 32'h3008, 5'd0, 2'd0, 2'd2, 2'd0, '0);
    tick();
    checks++; if (tuse_rs_o !== 2'd0 || tnew_o !== 2'd0) $display("FAIL sat_zero got=%0d/%0d exp=0/0", tuse_rs_o, tnew_o); else passed++;
    checks++; if (tuse_rt_o !== 2'd1) $display("FAIL sat_tuse_rt got=%0d exp=1", tuse_rt_o); else passed++;
    checks++; if (wr_pending_o !== 1'b0) $display("FAIL sat_wrp_a3zero got=%0b exp=0", wr_pending_o); else passed++;
    // Tnew has no sentinel: 3 decrements to 2.
    drive(1'b1, 32'h2222_0000, 32'h300C, 5'd7, 2'd3, 2'd3, 2'd3, '0);
    tick();
    checks++; if (tnew_o !== 2'd2) $display("FAIL tnew_max got=%0d exp=2", tnew_o); else passed++;
  endtask

  // ---------------------------------------------------------------- stall
  task automatic test_stall();
    int exp_big, exp_small;
    drive(1'b1, 32'h8C22_0004, 32'h3004, 5'd2, 2'd1, 2'd3, 2'd2, 96'h5A5A);
    tick();
    stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, $urandom, $urandom, 5'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), '1);
      tick();
      exp_big = k;
      exp_small = (k > 3) ? 3 : k;
      checks++; if (ins_o !== 32'h8C22_0004 || pc_o !== 32'h3004 || a3_o !== 5'd2) $display("FAIL stall_hold_data cyc=%0d got=%h/%h/%0d exp=8c220004/00003004/2", k, ins_o, pc_o, a3_o); else passed++;
      checks++; if (tuse_rs_o !== 2'd0 || tuse_rt_o !== 2'd3 || tnew_o !== 2'd1 || payload_o !== 96'h5A5A) $display("FAIL stall_hold_timers cyc=%0d got=%0d/%0d/%0d exp=0/3/1", k, tuse_rs_o, tuse_rt_o, tnew_o); else passed++;
      checks++; if (stall_cnt_o !== 8'(exp_big)) $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", k, stall_cnt_o, exp_big); else passed++;
      checks++; if (s_stall_cnt_o !== 2'(exp_small)) $display("FAIL stall_cnt_sat cyc=%0d got=%0d exp=%0d", k, s_stall_cnt_o, exp_small); else passed++;
    end
    stall = 1'b0;
    drive(1'b1, 32'hAC43_0008, 32'h3010, 5'd0, 2'd2, 2'd1, 2'd1, 96'h77);
    tick();
    checks++; if (ins_o !== 32'hAC43_0008 || pc_o !== 32'h3010) $display("FAIL stall_release_data got=%h/%h exp=ac430008/00003010", ins_o, pc_o); else passed++;
    checks++; if (stall_cnt_o !== 8'd0 || s_stall_cnt_o !== 2'd0) $display("FAIL stall_release_cnt got=%0d/%0d exp=0/0", stall_cnt_o, s_stall_cnt_o); else passed++;
  endtask

  // --------------------------------------------------------- flush vs stall
  task automatic test_flush_stall();
    drive(1'b1, 32'h0000_1234, 32'h3020, 5'd9, 2'd2, 2'd2, 2'd2, 96'h1);
    tick();
    stall = 1'b1; tick();
    flush = 1'b1; pc_i = 32'h0000_4444;
    tick();
    flush = 1'b0; stall = 1'b0;
    checks++; if (valid_o !== 1'b0 || wr_pending_o !== 1'b0) $display("FAIL flush_valid got=%0b/%0b exp=0/0", valid_o, wr_pending_o); else passed++;
    checks++; if (tuse_rs_o !== 2'd3 || tnew_o !== 2'd0 || ins_o !== 32'd0) $display("FAIL flush_bubble got=%0d/%0d/%h exp=3/0/0", tuse_rs_o, tnew_o, ins_o); else passed++;
    checks++; if (stall_cnt_o !== 8'd0) $display("FAIL flush_stall_cnt got=%0d exp=0", stall_cnt_o); else passed++;
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
    checks++; if (pc_o !== 32'h4444) $display("FAIL flush_pc got=%h exp=00004444", pc_o); else passed++;
    checks++; if (bubble_pc_vld_o !== 1'b1) $display("FAIL flush_bpv got=%0b exp=1", bubble_pc_vld_o); else passed++;
`else
    checks++; if (pc_o !== 32'h3000) $display("FAIL flush_pc got=%h exp=00003000", pc_o); else passed++;
`endif
  endtask

  // --------------------------------------------------------- invalid load
  task automatic test_invalid_load();
    drive(1'b0, 32'hFFFF_FFFF, 32'h5000, 5'd31, 2'd1, 2'd1, 2'd3, '1);
    tick();
    checks++; if (valid_o !== 1'b0 || a3_o !== 5'd0 || wr_pending_o !== 1'b0) $display("FAIL invalid_load got=%0b/%0d/%0b exp=0/0/0", valid_o, a3_o, wr_pending_o); else passed++;
    checks++; if (ins_o !== 32'd0 || payload_o !== '0 || pc_o !== 32'h3000) $display("FAIL invalid_load_data got=%h/%h exp=0/00003000", ins_o, pc_o); else passed++;
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
    checks++; if (bubble_pc_vld_o !== 1'b0) $display("FAIL invalid_load_bpv got=%0b exp=0", bubble_pc_vld_o); else passed++;
`endif
  endtask

  // --------------------------------------------------------------- random
  // Model: what a stage register should hold after each edge.
  logic          m_valid, m_bpv;
  logic [31:0]   m_ins, m_pc;
  logic [4:0]    m_a3;
  int            m_trs, m_trt, m_tn, m_cnt, m_cnt_s;
  logic [PW-1:0] m_pl;

  task automatic model_bubble(input logic [31:0] pc);
    m_valid = 1'b0; m_ins = '0; m_pc = pc; m_a3 = '0;
    m_trs = 3; m_trt = 3; m_tn = 0; m_pl = '0;
  endtask

  function automatic int tuse_after(input int t);
    if (t == 3) return 3;       // unused-operand sentinel
    return (t > 0) ? t - 1 : 0;
  endfunction

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    model_bubble(PCR); m_cnt = 0; m_cnt_s = 0; m_bpv = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom), {$urandom, $urandom, $urandom});
      if (reset) begin
        model_bubble(PCR); m_cnt = 0; m_cnt_s = 0; m_bpv = 1'b0;
      end else if (flush) begin
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
        model_bubble(pc_i);
`else
        model_bubble(PCR);
`endif
        m_cnt = 0; m_cnt_s = 0; m_bpv = 1'b1;
      end else if (stall) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : 3;
      end else begin
        m_cnt = 0; m_cnt_s = 0; m_bpv = 1'b0;
        if (valid_i) begin
          m_valid = 1'b1; m_ins = ins_i; m_pc = pc_i; m_a3 = a3_i; m_pl = payload_i;
          m_trs = tuse_after(int'(tuse_rs_i));
          m_trt = tuse_after(int'(tuse_rt_i));
          m_tn  = (tnew_i > 0) ? int'(tnew_i) - 1 : 0;
        end else begin
          model_bubble(PCR);
        end
      end
      tick();
      checks++;
      if (valid_o !== m_valid || ins_o !== m_ins || pc_o !== m_pc || a3_o !== m_a3 ||
          payload_o !== m_pl || wr_pending_o !== (m_valid && m_a3 != 0))
        $display("FAIL rand_fields n=%0d got v=%0b ins=%h pc=%h a3=%0d exp v=%0b ins=%h pc=%h a3=%0d",
                 n, valid_o, ins_o, pc_o, a3_o, m_valid, m_ins, m_pc, m_a3);
      else passed++;
      checks++;
      if (tuse_rs_o !== 2'(m_trs) || tuse_rt_o !== 2'(m_trt) || tnew_o !== 2'(m_tn))
        $display("FAIL rand_timers n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 n, tuse_rs_o, tuse_rt_o, tnew_o, m_trs, m_trt, m_tn);
      else passed++;
      checks++;
      if (stall_cnt_o !== 8'(m_cnt) || s_stall_cnt_o !== 2'(m_cnt_s))
        $display("FAIL rand_stall_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt_o, s_stall_cnt_o, m_cnt, m_cnt_s);
      else passed++;
`ifdef PIPE_KEEP_PC_ON_FLUSH_EN
      checks++;
      if (bubble_pc_vld_o !== m_bpv) $display("FAIL rand_bpv n=%0d got=%0b exp=%0b", n, bubble_pc_vld_o, m_bpv);
      else passed++;
`endif
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_saturation();
    test_stall();
    test_flush_stall();
    test_invalid_load();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
